exc_entry_sequencer: RTL and testbench
======================================

EXC_ENTRY_SEQUENCER -- requirements
Module: exc_entry_sequencer

Interface
REQ-001 Parameter: LR_OFFSET, default 4, added to captured PC to form the banked r14 value.
REQ-002 Parameter: VECTOR_BASE, default 32'h0, base of the exception vector table.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 exc_req  in  4  level exception requests {abt,irq,und,svc} = bits [3:0] = {3,2,1,0}; held by requester until acked.
REQ-006 cur_pc  in  32  PC of the faulting/current instruction.
REQ-007 cpsr_in  in  32  current CPSR value (bank register 16).
REQ-008 wb_req  in  1  pipeline writeback request.
REQ-009 wb_sel  in  5  writeback target register index.
REQ-010 wb_data  in  32  writeback data.
REQ-011 wb_gnt  out  1  writeback granted this cycle.
REQ-012 write_enable  out  1  register-bank write strobe.
REQ-013 write_sel  out  5  register-bank write index.
REQ-014 reg_in  out  32  register-bank write data.
REQ-015 exc_ack  out  4  one-hot, one-cycle acknowledge of the serviced request.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States: IDLE, SAVE_SPSR, SAVE_LR, SET_CPSR, SET_PC; SET_PC returns to IDLE unconditionally.
REQ-018 In IDLE, any qualified exc_req bit SHALL move the FSM to SAVE_SPSR at the next edge, latching cur_pc, cpsr_in and the selected mode.
REQ-019 Priority, highest first: abt, irq, und, svc; lower pending requests stay unserviced until a later IDLE cycle.
REQ-020 SAVE_SPSR writes latched CPSR to spsr_<mode> (svc 19, abt 22, irq 25, und 28).
REQ-021 SAVE_LR writes latched PC + LR_OFFSET (mod 2^32) to r14_<mode> (svc 18, abt 21, irq 24, und 27).
REQ-022 SET_CPSR writes latched CPSR with [4:0] replaced by mode (svc 5'b10011, abt 5'b10111, irq 5'b10010, und 5'b11011) and bit 7 (I) set to 1 to register 16.
REQ-023 SET_PC writes VECTOR_BASE + offset (und 0x04, svc 0x08, abt 0x10, irq 0x18) to register 15 and asserts the matching exc_ack bit in the same cycle.
REQ-024 write_enable SHALL be 1 in every non-IDLE state; exception entry is exactly 4 consecutive write cycles.
REQ-025 In IDLE with no qualified request: wb_gnt = wb_req, write_enable = wb_req, write_sel = wb_sel, reg_in = wb_data (combinational, zero latency).
REQ-026 Same-cycle qualified request and wb_req in IDLE: writeback wins that cycle (wb_gnt=1); exception is accepted at the same edge and sequenced from the next cycle.
REQ-027 wb_gnt SHALL be 0 whenever busy; the requester holds wb_* until granted.
REQ-028 Deassertion of exc_req mid-sequence SHALL NOT abort the sequence; ack still issues.
REQ-029 When not writing, write_sel and reg_in SHALL be 0.

Reset
REQ-030 reset SHALL force IDLE at the next edge; outputs write_enable, wb_gnt, exc_ack, busy = 0, write_sel = 0, reg_in = 0 while reset is high.
REQ-031 Reset mid-sequence abandons the sequence with no exc_ack and no further writes.

Configuration
REQ-032 Macro EXC_IRQ_MASK_EN defined: irq request qualifies only if cpsr_in[7] == 0. Undefined: irq qualifies regardless of cpsr_in[7]; other requests are never masked.

Structure
REQ-033 Shared package arm_pkg SHALL hold mode encodings, banked register index constants, vector offsets and the FSM state enum.
REQ-034 One sub-module exc_prio_enc: combinational 4-bit fixed-priority encoder producing one-hot grant and a valid bit.

Verification
REQ-035 svc request, cpsr_in=32'h10, cur_pc=32'h100 -> writes (19,32'h10),(18,32'h104),(16,32'h93),(15,32'h08) on 4 cycles; exc_ack=4'b0001 in 4th.
REQ-036 exc_req=4'b1100 simultaneously -> abt serviced first (PC=32'h10), irq serviced after return to IDLE (PC=32'h18).
REQ-037 wb_req with wb_sel=3, wb_data=32'hDEAD during busy -> wb_gnt=0 until IDLE; then write (3,32'hDEAD) with wb_gnt=1.
REQ-038 EXC_IRQ_MASK_EN defined, irq request with cpsr_in[7]=1 -> no writes, no ack; clear bit 7 -> sequence runs.
REQ-039 reset pulsed in SAVE_LR -> next cycle IDLE, write_enable=0, exc_ack never asserted.
REQ-040 cur_pc=32'hFFFFFFFE, und request -> r14_und (27) written with 32'h00000002.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - mode encodings, banked register indices, vector offsets and FSM states
package arm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_SPSR,
        ST_SAVE_LR,
        ST_SET_CPSR,
        ST_SET_PC
    } exc_state_t;

    // Request bit positions inside exc_req
    localparam int EXC_SVC = 0;
    localparam int EXC_UND = 1;
    localparam int EXC_IRQ = 2;
    localparam int EXC_ABT = 3;

    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_UND = 5'b11011;

    localparam logic [4:0] REG_PC       = 5'd15;
    localparam logic [4:0] REG_CPSR     = 5'd16;
    localparam logic [4:0] REG_R14_SVC  = 5'd18;
    localparam logic [4:0] REG_SPSR_SVC = 5'd19;
    localparam logic [4:0] REG_R14_ABT  = 5'd21;
    localparam logic [4:0] REG_SPSR_ABT = 5'd22;
    localparam logic [4:0] REG_R14_IRQ  = 5'd24;
    localparam logic [4:0] REG_SPSR_IRQ = 5'd25;
    localparam logic [4:0] REG_R14_UND  = 5'd27;
    localparam logic [4:0] REG_SPSR_UND = 5'd28;

    localparam logic [31:0] VEC_UND = 32'h04;
    localparam logic [31:0] VEC_SVC = 32'h08;
    localparam logic [31:0] VEC_ABT = 32'h10;
    localparam logic [31:0] VEC_IRQ = 32'h18;

    typedef struct packed {
        logic [4:0]  mode;
        logic [4:0]  spsr_idx;
        logic [4:0]  lr_idx;
        logic [31:0] vec_off;
    } exc_info_t;

    function automatic exc_info_t exc_info(input logic [3:0] onehot);
        exc_info_t info;
        case (onehot)
            4'b1000: info = '{MODE_ABT, REG_SPSR_ABT, REG_R14_ABT, VEC_ABT};
            4'b0100: info = '{MODE_IRQ, REG_SPSR_IRQ, REG_R14_IRQ, VEC_IRQ};
            4'b0010: info = '{MODE_UND, REG_SPSR_UND, REG_R14_UND, VEC_UND};
            default: info = '{MODE_SVC, REG_SPSR_SVC, REG_R14_SVC, VEC_SVC};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - fixed-priority one-hot encoder, bit 3 highest
module exc_prio_enc (
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       valid
);

    always_comb begin
        grant = 4'b0000;
        if (req[3])      grant = 4'b1000;
        else if (req[2]) grant = 4'b0100;
        else if (req[1]) grant = 4'b0010;
        else if (req[0]) grant = 4'b0001;
    end

    assign valid = |req;

endmodule

// File: rtl/exc_entry_sequencer.sv
// rtl/exc_entry_sequencer.sv - exception entry register-bank write sequencer; EXC_IRQ_MASK_EN gates irq on CPSR.I
module exc_entry_sequencer
    import arm_pkg::*;
#(
    parameter logic [31:0] LR_OFFSET   = 32'd4,
    parameter logic [31:0] VECTOR_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  exc_req,
    input  logic [31:0] cur_pc,
    input  logic [31:0] cpsr_in,
    input  logic        wb_req,
    input  logic [4:0]  wb_sel,
    input  logic [31:0] wb_data,
    output logic        wb_gnt,
    output logic        write_enable,
    output logic [4:0]  write_sel,
    output logic [31:0] reg_in,
    output logic [3:0]  exc_ack,
    output logic        busy
);

    exc_state_t  state;
    logic [3:0]  qual_req;
    logic [3:0]  grant;
    logic        grant_valid;
    exc_info_t   grant_info;

    logic [3:0]  grant_q;
    logic [4:0]  lr_idx_q;
    logic [31:0] lr_q;
    logic [31:0] new_cpsr_q;
    logic [31:0] vec_q;
    logic [4:0]  seq_sel;
    logic [31:0] seq_data;
    logic [3:0]  seq_ack;

    always_comb begin
        qual_req = exc_req;
`ifdef EXC_IRQ_MASK_EN
        if (cpsr_in[7]) qual_req[EXC_IRQ] = 1'b0;
`else
        qual_req[EXC_IRQ] = exc_req[EXC_IRQ];
`endif
    end

    exc_prio_enc u_prio (
        .req   (qual_req),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_info = exc_info(grant);

    // Everything needed later is captured at acceptance, so requests and
    // CPU state may change freely once the sequence has started.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            lr_idx_q   <= '0;
            lr_q       <= '0;
            new_cpsr_q <= '0;
            vec_q      <= '0;
            seq_sel    <= '0;
            seq_data   <= '0;
            seq_ack    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state      <= ST_SAVE_SPSR;
                        grant_q    <= grant;
                        lr_idx_q   <= grant_info.lr_idx;
                        lr_q       <= cur_pc + LR_OFFSET;
                        new_cpsr_q <= {cpsr_in[31:8], 1'b1, cpsr_in[6:5], grant_info.mode};
                        vec_q      <= VECTOR_BASE + grant_info.vec_off;
                        seq_sel    <= grant_info.spsr_idx;
                        seq_data   <= cpsr_in;
                        seq_ack    <= '0;
                    end
                end
                ST_SAVE_SPSR: begin
                    state    <= ST_SAVE_LR;
                    seq_sel  <= lr_idx_q;
                    seq_data <= lr_q;
                end
                ST_SAVE_LR: begin
                    state    <= ST_SET_CPSR;
                    seq_sel  <= REG_CPSR;
                    seq_data <= new_cpsr_q;
                end
                ST_SET_CPSR: begin
                    state    <= ST_SET_PC;
                    seq_sel  <= REG_PC;
                    seq_data <= vec_q;
                    seq_ack  <= grant_q;
                end
                ST_SET_PC: begin
                    state    <= ST_IDLE;
                    seq_sel  <= '0;
                    seq_data <= '0;
                    seq_ack  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Writeback always owns the bank in IDLE, including the acceptance cycle.
    always_comb begin
        wb_gnt       = 1'b0;
        write_enable = 1'b0;
        write_sel    = '0;
        reg_in       = '0;
        exc_ack      = '0;
        busy         = 1'b0;
        if (!reset) begin
            if (state == ST_IDLE) begin
                wb_gnt       = wb_req;
                write_enable = wb_req;
                if (wb_req) begin
                    write_sel = wb_sel;
                    reg_in    = wb_data;
                end
            end else begin
                busy         = 1'b1;
                write_enable = 1'b1;
                write_sel    = seq_sel;
                reg_in       = seq_data;
                exc_ack      = seq_ack;
            end
        end
    end

endmodule

// File: tb/tb_exc_entry_sequencer.sv
// tb/tb_exc_entry_sequencer.sv - self-checking bench for exc_entry_sequencer
module tb_exc_entry_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  exc_req;
    logic [31:0] cur_pc;
    logic [31:0] cpsr_in;
    logic        wb_req;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        wb_gnt;
    logic        write_enable;
    logic [4:0]  write_sel;
    logic [31:0] reg_in;
    logic [3:0]  exc_ack;
    logic        busy;

    always #5 clk = ~clk;

    exc_entry_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .exc_req      (exc_req),
        .cur_pc       (cur_pc),
        .cpsr_in      (cpsr_in),
        .wb_req       (wb_req),
        .wb_sel       (wb_sel),
        .wb_data      (wb_data),
        .wb_gnt       (wb_gnt),
        .write_enable (write_enable),
        .write_sel    (write_sel),
        .reg_in       (reg_in),
        .exc_ack      (exc_ack),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Indexed by request bit: svc, und, irq, abt
    logic [4:0]  spsr_idx [4] = '{5'd19, 5'd28, 5'd25, 5'd22};
    logic [4:0]  lr_idx   [4] = '{5'd18, 5'd27, 5'd24, 5'd21};
    logic [4:0]  mode_bits[4] = '{5'h13, 5'h1B, 5'h12, 5'h17};
    logic [31:0] vec_off  [4] = '{32'h08, 32'h04, 32'h18, 32'h10};

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
        logic [3:0]  ack;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] pc;
        logic [31:0] cpsr;
        logic [4:0]  sel [4];
        logic [31:0] data[4];
        logic [3:0]  ack;
    } vec_t;
    vec_t tbl[4];

    logic        last_we, last_gnt, last_busy;
    logic [4:0]  last_sel;
    logic [31:0] last_data;
    logic [3:0]  last_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: inputs already driven; model predicts outputs, compare at negedge.
    task automatic step();
        logic [3:0]  q;
        logic [43:0] e;
        wr_t         w;
        int          pick;
        @(negedge clk);
        if (reset) begin
            e = '0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            e = {1'b1, w.sel, w.data, 1'b0, w.ack, 1'b1};
        end else begin
            e = {wb_req, wb_req ? wb_sel : 5'd0, wb_req ? wb_data : 32'd0, wb_req, 4'd0, 1'b0};
            q = exc_req;
`ifdef EXC_IRQ_MASK_EN
            if (cpsr_in[7]) q[2] = 1'b0;
`endif
            pick = -1;
            for (int b = 3; b >= 0; b--)
                if (q[b] && pick < 0) pick = b;
            if (pick >= 0) begin
                exp_q.push_back('{spsr_idx[pick], cpsr_in, 4'd0});
                exp_q.push_back('{lr_idx[pick], cur_pc + 32'd4, 4'd0});
                exp_q.push_back('{5'd16, (cpsr_in & 32'hFFFF_FFE0) | 32'h80 | {27'd0, mode_bits[pick]}, 4'd0});
                exp_q.push_back('{5'd15, vec_off[pick], 4'b0001 << pick});
            end
        end
        check("cycle", {20'd0, write_enable, write_sel, reg_in, wb_gnt, exc_ack, busy}, {20'd0, e});
        last_we   = write_enable;
        last_sel  = write_sel;
        last_data = reg_in;
        last_gnt  = wb_gnt;
        last_ack  = exc_ack;
        last_busy = busy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_busy;
        tbl[0] = '{4'b0001, 32'h0000_0100, 32'h0000_0010, '{5'd19, 5'd18, 5'd16, 5'd15},
                   '{32'h10, 32'h104, 32'h93, 32'h08}, 4'b0001};
        tbl[1] = '{4'b0010, 32'hFFFF_FFFE, 32'h0000_0000, '{5'd28, 5'd27, 5'd16, 5'd15},
                   '{32'h0, 32'h2, 32'h9B, 32'h04}, 4'b0010};
        tbl[2] = '{4'b1000, 32'h0000_2000, 32'hF000_0010, '{5'd22, 5'd21, 5'd16, 5'd15},
                   '{32'hF000_0010, 32'h2004, 32'hF000_0097, 32'h10}, 4'b1000};
        tbl[3] = '{4'b0100, 32'h0000_0040, 32'h0000_007F, '{5'd25, 5'd24, 5'd16, 5'd15},
                   '{32'h7F, 32'h44, 32'hF2, 32'h18}, 4'b0100};

        reset = 1'b1; exc_req = 4'b0001; cur_pc = 32'h0; cpsr_in = 32'h0;
        wb_req = 1'b1; wb_sel = 5'd5; wb_data = 32'h1;
        step();
        step();
        check("reset_state", {last_we, last_gnt, last_ack, last_busy, last_sel, last_data},
              {1'b0, 1'b0, 4'd0, 1'b0, 5'd0, 32'd0});
        reset = 1'b0; exc_req = 4'b0000;

        wb_req = 1'b1; wb_sel = 5'd9; wb_data = 32'hCAFE_F00D;
        step();
        check("wb_pass", {last_we, last_gnt, last_sel, last_data}, {1'b1, 1'b1, 5'd9, 32'hCAFE_F00D});
        wb_req = 1'b0;
        step();
        check("idle_zero", {last_we, last_gnt, last_sel, last_data}, {1'b0, 1'b0, 5'd0, 32'd0});

        for (int i = 0; i < 4; i++) begin
            exc_req = tbl[i].req; cur_pc = tbl[i].pc; cpsr_in = tbl[i].cpsr;
            step();
            check($sformatf("tbl%0d_accept", i), {last_we, last_busy}, {1'b0, 1'b0});
            cur_pc = 32'h5555_AAAA; cpsr_in = 32'h0;
            for (int k = 0; k < 4; k++) begin
                step();
                check($sformatf("tbl%0d_w%0d", i, k), {last_we, last_sel, last_data, last_ack},
                      {1'b1, tbl[i].sel[k], tbl[i].data[k], (k == 3) ? tbl[i].ack : 4'd0});
            end
            exc_req = 4'b0000;
        end

        // abt and irq together: abt first, irq after returning to IDLE
        cpsr_in = 32'h0; cur_pc = 32'h300; exc_req = 4'b1100;
        step();
        for (int k = 0; k < 4; k++) step();
        check("prio_abt", {last_data, last_ack}, {32'h10, 4'b1000});
        exc_req = 4'b0100;
        step();
        check("prio_gap", {last_we, last_busy}, {1'b0, 1'b0});
        for (int k = 0; k < 4; k++) step();
        check("prio_irq", {last_data, last_ack}, {32'h18, 4'b0100});
        exc_req = 4'b0000;

        // Writeback held off while busy
        exc_req = 4'b0001;
        step();
        wb_req = 1'b1; wb_sel = 5'd3; wb_data = 32'hDEAD;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("wb_block%0d", k), {last_gnt, last_busy}, {1'b0, 1'b1});
        end
        exc_req = 4'b0000;
        step();
        check("wb_after", {last_we, last_gnt, last_sel, last_data}, {1'b1, 1'b1, 5'd3, 32'hDEAD});
        wb_req = 1'b0;

        // Same-cycle writeback and request
        exc_req = 4'b0001; wb_req = 1'b1; wb_sel = 5'd7; wb_data = 32'h1234;
        step();
        check("same_cycle_wb", {last_gnt, last_sel, last_data}, {1'b1, 5'd7, 32'h1234});
        wb_req = 1'b0;
        step();
        check("same_cycle_exc", {last_we, last_sel}, {1'b1, 5'd19});
        for (int k = 0; k < 3; k++) step();
        exc_req = 4'b0000;

        // Reset during SAVE_LR abandons the sequence
        exc_req = 4'b0010;
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_mid", {last_we, last_busy, last_ack}, {1'b0, 1'b0, 4'd0});
        reset = 1'b0; exc_req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rst_after%0d", k), {last_we, last_busy, last_ack}, {1'b0, 1'b0, 4'd0});
        end

        // Request dropped mid-sequence still completes
        exc_req = 4'b1000;
        step();
        exc_req = 4'b0000;
        for (int k = 0; k < 4; k++) step();
        check("drop_ack", {last_sel, last_ack}, {5'd15, 4'b1000});

        // irq with CPSR.I set
        exc_req = 4'b0100; cpsr_in = 32'h80;
        step();
        step();
`ifdef EXC_IRQ_MASK_EN
        exp_busy = 1'b0;
`else
        exp_busy = 1'b1;
`endif
        check("irq_mask", {31'd0, last_busy}, {31'd0, exp_busy});
        cpsr_in = 32'h0;
        for (int k = 0; k < 12 && exc_req != 4'b0000; k++) begin
            step();
            exc_req = exc_req & ~last_ack;
        end
        check("irq_unmask_done", {60'd0, exc_req}, 64'd0);
        for (int k = 0; k < 4; k++) step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) exc_req = exc_req | 4'($urandom_range(0, 15));
            cur_pc  = $urandom;
            cpsr_in = $urandom;
            if (!wb_req && $urandom_range(0, 3) == 0) begin
                wb_req  = 1'b1;
                wb_sel  = 5'($urandom);
                wb_data = $urandom;
            end
            step();
            exc_req = exc_req & ~last_ack;
            if (last_gnt) wb_req = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
